// File: rtl/mole_draw_scheduler_if.sv
// Pixel-plot bus between the mole draw scheduler and its requester/VGA side.
// The scheduler uses the slave view; the requester/observer uses the master view.
interface mole_draw_scheduler_if;
   logic [2:0] mole;
   logic       clear;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       busy;
   logic [2:0] shown;

   modport master (
      output mole, clear,
      input  x, y, colour, plot, busy, shown
   );

   modport slave (
      input  mole, clear,
      output x, y, colour, plot, busy, shown
   );
endinterface

// File: rtl/mole_draw_scheduler.sv
// Repaints the three mole boxes pixel by pixel whenever the requested mole state
// differs from what is on screen; round-robin between boxes, clear-all has priority.
module mole_draw_scheduler #(
   parameter int unsigned BOX_W    = 8,
   parameter int unsigned BOX_H    = 8,
   parameter int unsigned X_BASE0  = 1,
   parameter int unsigned X_BASE1  = 9,
   parameter int unsigned X_BASE2  = 17,
   parameter int unsigned Y_TOP    = 33,
   parameter logic [2:0]  COL_UP   = 3'b100,
   parameter logic [2:0]  COL_DOWN = 3'b000
) (
   input logic                  clock,
   input logic                  resetn,
   mole_draw_scheduler_if.slave bus
);

   typedef enum logic [1:0] {IDLE, BOX, CLEAR} state_t;

   state_t     state;
   logic [1:0] slot;
   logic [1:0] rr_ptr;
   logic [1:0] pick;
   logic       col;
   logic       clr_pend;
   logic [3:0] col_cnt;
   logic [3:0] row;
   logic [2:0] shown_r;
   logic [2:0] colour_r;
   logic [2:0] dirty;
   logic [7:0] x_r;
   logic [7:0] x_base;
   logic [6:0] y_r;
   logic       plot_r;
   logic       busy_r;
   logic       last_col;
   logic       last_row;

   function automatic logic [1:0] next_slot(input logic [1:0] s);
      return (s == 2'd2) ? 2'd0 : s + 2'd1;
   endfunction

   // First dirty box at or after rr_ptr, wrapping mod 3.
   always_comb begin
      dirty = bus.mole ^ shown_r;
      if (dirty[rr_ptr])
         pick = rr_ptr;
      else if (dirty[next_slot(rr_ptr)])
         pick = next_slot(rr_ptr);
      else
         pick = next_slot(next_slot(rr_ptr));
   end

   always_comb begin
      case (slot)
         2'd0:    x_base = 8'(X_BASE0);
         2'd1:    x_base = 8'(X_BASE1);
         default: x_base = 8'(X_BASE2);
      endcase
      last_col = (col_cnt == 4'(BOX_W - 1));
      last_row = (row == 4'(BOX_H - 1));
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         slot     <= '0;
         rr_ptr   <= '0;
         col      <= 1'b0;
         clr_pend <= 1'b0;
         col_cnt  <= '0;
         row      <= '0;
         shown_r  <= '0;
         x_r      <= '0;
         y_r      <= '0;
         colour_r <= '0;
         plot_r   <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               plot_r <= 1'b0;
               if (bus.clear || clr_pend) begin
                  state    <= CLEAR;
                  busy_r   <= 1'b1;
                  slot     <= '0;
                  clr_pend <= 1'b0;
                  col      <= 1'b0;
                  col_cnt  <= '0;
                  row      <= '0;
               end else if (dirty != '0) begin
                  state   <= BOX;
                  busy_r  <= 1'b1;
                  slot    <= pick;
                  col     <= bus.mole[pick];
                  col_cnt <= '0;
                  row     <= '0;
               end
            end
            BOX, CLEAR: begin
               if (bus.clear)
                  clr_pend <= 1'b1;
               plot_r   <= 1'b1;
               x_r      <= x_base + {4'd0, col_cnt};
               y_r      <= 7'(Y_TOP) + {3'd0, row};
               colour_r <= (state == BOX && col) ? COL_UP : COL_DOWN;
               if (last_col) begin
                  col_cnt <= '0;
                  row     <= last_row ? '0 : row + 4'd1;
               end else begin
                  col_cnt <= col_cnt + 4'd1;
               end
               // CLEAR walks slots 0..2 back to back with no idle gap.
               if (last_col && last_row) begin
                  if (state == BOX) begin
                     shown_r[slot] <= col;
                     rr_ptr        <= next_slot(slot);
                     state         <= IDLE;
                     busy_r        <= 1'b0;
                  end else if (slot == 2'd2) begin
                     shown_r <= '0;
                     state   <= IDLE;
                     busy_r  <= 1'b0;
                  end else begin
                     slot <= slot + 2'd1;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               plot_r <= 1'b0;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.x      = x_r;
   assign bus.y      = y_r;
   assign bus.colour = colour_r;
   assign bus.plot   = plot_r;
   assign bus.busy   = busy_r;
   assign bus.shown  = shown_r;

endmodule

// File: tb/tb_mole_draw_scheduler.sv
// Directed bench for mole_draw_scheduler: table of single-box jobs plus
// hand-written sequences for round-robin, clear, mid-box changes and reset abort.
module tb_mole_draw_scheduler;
   localparam int         BOX_W = 8;
   localparam int         BOX_H = 8;
   localparam int         Y_TOP = 33;
   localparam logic [2:0] RED   = 3'b100;
   localparam logic [2:0] BLACK = 3'b000;

   typedef struct {
      string      name;
      logic [2:0] mole;
      int         slot;
      logic [2:0] colour;
      logic [2:0] shown;
   } vec_t;

   logic clock  = 1'b0;
   logic resetn = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic span_en    = 1'b0;
   int   first_busy = -1;
   int   last_busy  = -1;

   mole_draw_scheduler_if bus ();

   mole_draw_scheduler #(
      .BOX_W(8), .BOX_H(8), .X_BASE0(1), .X_BASE1(9), .X_BASE2(17),
      .Y_TOP(33), .COL_UP(3'b100), .COL_DOWN(3'b000)
   ) dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   always @(negedge clock)
      if (span_en && bus.busy === 1'b1) begin
         if (first_busy < 0) first_busy = cyc;
         last_busy = cyc;
      end

   function automatic int xbase(input int s);
      case (s)
         0:       return 1;
         1:       return 9;
         default: return 17;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Called right after mole is driven at a negedge; returns negedges until first plot.
   task automatic wait_plot(output int lat);
      lat = 0;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clock);
         if (bus.plot === 1'b1) begin
            lat = n;
            break;
         end
      end
   endtask

   // Entered at the negedge showing pixel 0; leaves at the negedge after the last pixel.
   task automatic check_box(input string name, input int s, input logic [2:0] c,
                            input int a_at, input logic [2:0] a_mole, input logic a_clr,
                            input int b_at, input logic [2:0] b_mole);
      int bad = 0;
      int bi = 0, bx = 0, by = 0, bc = 0, bp = 0;
      for (int i = 0; i < BOX_W * BOX_H; i++) begin
         bus.clear = 1'b0;
         if (bus.plot !== 1'b1 || int'(bus.x) != xbase(s) + i % BOX_W ||
             int'(bus.y) != Y_TOP + i / BOX_W || bus.colour !== c) begin
            if (bad == 0) begin
               bi = i; bp = int'(bus.plot); bx = int'(bus.x);
               by = int'(bus.y); bc = int'(bus.colour);
            end
            bad++;
         end
         if (i == a_at) begin
            bus.mole  = a_mole;
            bus.clear = a_clr;
         end
         if (i == b_at) bus.mole = b_mole;
         @(negedge clock);
      end
      bus.clear = 1'b0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL %s: %0d bad pixels, first #%0d got plot=%0d x=%0d y=%0d colour=%0d expected plot=1 x=%0d y=%0d colour=%0d",
                  name, bad, bi, bp, bx, by, bc, xbase(s) + bi % BOX_W, Y_TOP + bi / BOX_W, int'(c));
      end
   endtask

   task automatic run_single(input vec_t v);
      int lat;
      bus.mole = v.mole;
      wait_plot(lat);
      chk({v.name, "_latency"}, lat, 2);
      check_box({v.name, "_raster"}, v.slot, v.colour, -1, 3'b000, 1'b0, -1, 3'b000);
      chk({v.name, "_idle_plot"}, int'(bus.plot), 0);
      chk({v.name, "_idle_busy"}, int'(bus.busy), 0);
      chk({v.name, "_shown"}, int'(bus.shown), int'(v.shown));
      @(negedge clock);
      chk({v.name, "_settled"}, int'(bus.plot), 0);
   endtask

   initial begin
      vec_t vt[6];
      vec_t pre;
      int   lat;
      int   cnt;

      vt[0] = '{"t2_box1_up",   3'b010, 1, RED,   3'b010};
      vt[1] = '{"box0_up",      3'b011, 0, RED,   3'b011};
      vt[2] = '{"box1_down",    3'b001, 1, BLACK, 3'b001};
      vt[3] = '{"box2_up",      3'b101, 2, RED,   3'b101};
      vt[4] = '{"box0_down",    3'b100, 0, BLACK, 3'b100};
      vt[5] = '{"box2_down",    3'b000, 2, BLACK, 3'b000};

      // Reset held, then quiet idle with no request.
      bus.mole  = 3'b000;
      bus.clear = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_plot", int'(bus.plot), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_shown", int'(bus.shown), 0);
      chk("rst_x", int'(bus.x), 0);
      chk("rst_y", int'(bus.y), 0);
      chk("rst_colour", int'(bus.colour), 0);
      resetn = 1'b1;
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (bus.plot === 1'b1 || bus.busy === 1'b1) cnt++;
      end
      chk("t1_quiet_cycles", cnt, 0);
      chk("t1_shown", int'(bus.shown), 0);

      for (int i = 0; i < 6; i++) run_single(vt[i]);

      // All three dirty with rr_ptr=0: 0,1,2 with one idle gap each.
      first_busy = -1;
      span_en    = 1'b1;
      bus.mole   = 3'b111;
      wait_plot(lat);
      chk("t3_latency", lat, 2);
      check_box("t3_box0", 0, RED, -1, 3'b000, 1'b0, -1, 3'b000);
      chk("t3_gap0", int'(bus.plot), 0);
      @(negedge clock);
      check_box("t3_box1", 1, RED, -1, 3'b000, 1'b0, -1, 3'b000);
      chk("t3_gap1", int'(bus.plot), 0);
      @(negedge clock);
      check_box("t3_box2", 2, RED, -1, 3'b111, 1'b0, -1, 3'b000);
      span_en = 1'b0;
      chk("t3_busy_span", last_busy - first_busy + 1, 194);
      chk("t3_shown", int'(bus.shown), 7);
      chk("t3_end_busy", int'(bus.busy), 0);

      // Clear during box 0 (also the cycle where dirty boxes compete with CLEAR).
      bus.mole = 3'b110;
      wait_plot(lat);
      chk("t5_latency", lat, 2);
      check_box("t5_box0", 0, BLACK, 4, 3'b000, 1'b1, -1, 3'b000);
      chk("t5_gap", int'(bus.plot), 0);
      @(negedge clock);
      check_box("t5_clr0", 0, BLACK, -1, 3'b000, 1'b0, -1, 3'b000);
      check_box("t5_clr1", 1, BLACK, -1, 3'b000, 1'b0, -1, 3'b000);
      check_box("t5_clr2", 2, BLACK, -1, 3'b000, 1'b0, -1, 3'b000);
      chk("t5_end_plot", int'(bus.plot), 0);
      chk("t5_end_busy", int'(bus.busy), 0);
      chk("t5_shown", int'(bus.shown), 0);
      @(negedge clock);

      // mole drops at the 10th plot of box 1; then a toggle that returns in time.
      bus.mole = 3'b010;
      wait_plot(lat);
      chk("t4_latency", lat, 2);
      check_box("t4_box1_red", 1, RED, 9, 3'b000, 1'b0, -1, 3'b000);
      chk("t4_gap", int'(bus.plot), 0);
      chk("t4_mid_shown", int'(bus.shown), 2);
      @(negedge clock);
      check_box("t4_box1_black", 1, BLACK, 20, 3'b100, 1'b0, 40, 3'b000);
      chk("t4_shown", int'(bus.shown), 0);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (bus.plot === 1'b1) cnt++;
      end
      chk("t4_toggle_no_write", cnt, 0);

      pre = '{"pre6_box0_up", 3'b001, 0, RED, 3'b001};
      run_single(pre);

      // Reset at the 30th plot of box 2 aborts the box and the round-robin pointer.
      bus.mole = 3'b101;
      wait_plot(lat);
      chk("t6_latency", lat, 2);
      repeat (29) @(negedge clock);
      chk("t6_x_at_30th", int'(bus.x), 22);
      chk("t6_plot_at_30th", int'(bus.plot), 1);
      resetn = 1'b0;
      #1;
      chk("t6_async_plot", int'(bus.plot), 0);
      chk("t6_async_busy", int'(bus.busy), 0);
      chk("t6_async_shown", int'(bus.shown), 0);
      chk("t6_async_x", int'(bus.x), 0);
      @(negedge clock);
      chk("t6_held_plot", int'(bus.plot), 0);
      bus.mole = 3'b111;
      resetn   = 1'b1;
      wait_plot(lat);
      chk("t6_restart_latency", lat, 2);
      check_box("t6_box0", 0, RED, -1, 3'b000, 1'b0, -1, 3'b000);
      @(negedge clock);
      check_box("t6_box1", 1, RED, -1, 3'b000, 1'b0, -1, 3'b000);
      @(negedge clock);
      check_box("t6_box2", 2, RED, -1, 3'b000, 1'b0, -1, 3'b000);
      chk("t6_shown", int'(bus.shown), 7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
